alu_sequencer: RTL

- Fetch/execute controller for the 4-bit ALU + ACC + R0 datapath.
- Reads 8-bit instructions from an external program ROM addressed by its program counter.
- Drives the ALU operand IN0, the ALU OP code and the CE_ACC / CE_R0 register enables.
- Sits between the program ROM and the datapath; the datapath itself is unchanged.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_decoder.sv | 48 ++++
 rtl/alu_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU fetch/execute sequencer: ALU op-codes,
// instruction opcodes and the FSM state encoding.
package alu_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int OP_WIDTH   = 2;
  localparam int ADDR_WIDTH = 4;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASS0 = 2'b01;
  localparam logic [1:0] ALU_INC   = 2'b10;
  localparam logic [1:0] ALU_PASS1 = 2'b11;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_LDI  = 4'h1;
  localparam logic [3:0] OPC_ADDI = 4'h2;
  localparam logic [3:0] OPC_INC  = 4'h3;
  localparam logic [3:0] OPC_STR  = 4'h4;
  localparam logic [3:0] OPC_LDR  = 4'h5;
  localparam logic [3:0] OPC_JMP  = 4'h6;
  localparam logic [3:0] OPC_JZ   = 4'h7;
  localparam logic [3:0] OPC_HLT  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction decoder: IR + FSM state to datapath controls.
// Everything is forced low outside EXEC so an async reset drops enables at once.
module alu_decoder
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int OP_WIDTH   = alu_pkg::OP_WIDTH
) (
  input  logic [1:0]            state,
  input  logic [7:0]            ir,
  input  logic                  acc_zero,
  output logic [DATA_WIDTH-1:0] in0,
  output logic [OP_WIDTH-1:0]   op,
  output logic                  ce_acc,
  output logic                  ce_r0,
  output logic                  illegal,
  output logic                  jump_taken,
  output logic                  halt
);

  logic [DATA_WIDTH-1:0] imm;
  assign imm = DATA_WIDTH'(ir[3:0]);

  always_comb begin
    in0        = '0;
    op         = OP_WIDTH'(ALU_ADD);
    ce_acc     = 1'b0;
    ce_r0      = 1'b0;
    illegal    = 1'b0;
    jump_taken = 1'b0;
    halt       = 1'b0;
    if (state == S_EXEC) begin
      case (ir[7:4])
        OPC_NOP:  ;
        OPC_LDI:  begin in0 = imm; op = OP_WIDTH'(ALU_PASS0); ce_acc = 1'b1; end
        OPC_ADDI: begin in0 = imm; op = OP_WIDTH'(ALU_ADD);   ce_acc = 1'b1; end
        OPC_INC:  begin in0 = imm; op = OP_WIDTH'(ALU_INC);   ce_acc = 1'b1; end
        OPC_STR:  ce_r0 = 1'b1;
        OPC_LDR:  begin op = OP_WIDTH'(ALU_PASS1); ce_acc = 1'b1; end
        OPC_JMP:  jump_taken = 1'b1;
        OPC_JZ:   jump_taken = acc_zero;
        OPC_HLT:  halt = 1'b1;
        default:  illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute controller for the 4-bit ALU + ACC + R0 datapath.
// Two cycles per instruction; register writes land on the EXEC->FETCH edge.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int OP_WIDTH   = alu_pkg::OP_WIDTH,
  parameter int ADDR_WIDTH = alu_pkg::ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [7:0]            INSTR,
  input  logic [DATA_WIDTH-1:0] ACC_IN,
  output logic [ADDR_WIDTH-1:0] PC_OUT,
  output logic [DATA_WIDTH-1:0] IN0,
  output logic [OP_WIDTH-1:0]   OP,
  output logic                  CE_ACC,
  output logic                  CE_R0,
  output logic                  BUSY,
  output logic                  HALTED,
  output logic                  ILLEGAL
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [7:0]            ir;
  logic                  busy;
  logic                  halted;
  logic                  jump_taken;
  logic                  halt;

  alu_decoder #(
    .DATA_WIDTH (DATA_WIDTH),
    .OP_WIDTH   (OP_WIDTH)
  ) u_decoder (
    .state      (state),
    .ir         (ir),
    .acc_zero   (ACC_IN == '0),
    .in0        (IN0),
    .op         (OP),
    .ce_acc     (CE_ACC),
    .ce_r0      (CE_R0),
    .illegal    (ILLEGAL),
    .jump_taken (jump_taken),
    .halt       (halt)
  );

  // BUSY/HALTED are separate flops so they never glitch on a state-bit change
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir     <= 8'h00;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (START) begin
            pc     <= '0;
            state  <= S_FETCH;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= INSTR;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (halt) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
            if (jump_taken) pc <= ADDR_WIDTH'(ir[3:0]);
            else            pc <= pc + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

  assign PC_OUT = pc;
  assign BUSY   = busy;
  assign HALTED = halted;

endmodule
